// File: rtl/cu_multicycle.sv
// cu_multicycle: multi-cycle control unit sequencing NOP/ALU/LOAD/STORE through DECODE/EXECUTE/MEM_ACCESS/WRITE_BACK.
// Optional feature: define CU_REG0_ZERO_EN to hardwire register 0 to zero.
module cu_multicycle #(
    parameter int DATA_WIDTH    = 8,
    parameter int REG_ADDR_BITS = 2,
    parameter int OFFSET_WIDTH  = 8,
    parameter int OPCODE_WIDTH  = 4,
    localparam int INSTR_WIDTH  = 2 + 3*REG_ADDR_BITS + OFFSET_WIDTH + OPCODE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [INSTR_WIDTH-1:0]   instr,
    input  logic [DATA_WIDTH-1:0]    result2,
    output logic [DATA_WIDTH-1:0]    operand1,
    output logic [DATA_WIDTH-1:0]    operand2,
    output logic [DATA_WIDTH-1:0]    offset,
    output logic [OPCODE_WIDTH-1:0]  opcode,
    output logic                     sel1,
    output logic                     sel3,
    output logic                     w_r,
    output logic                     busy,
    output logic                     done,
    input  logic [REG_ADDR_BITS-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]    dbg_data
);
    localparam int NUM_REGS = 1 << REG_ADDR_BITS;
    localparam logic [1:0] T_NOP = 2'd0, T_ALU = 2'd1, T_LOAD = 2'd2, T_STORE = 2'd3;
`ifdef CU_REG0_ZERO_EN
    localparam bit REG0_ZERO = 1'b1;
`else
    localparam bit REG0_ZERO = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, DECODE, EXECUTE, MEM_ACCESS, WRITE_BACK} state_t;

    state_t                   state;
    logic [1:0]               cur_type;
    logic [REG_ADDR_BITS-1:0] cur_rd;
    logic [DATA_WIDTH-1:0]    regfile [NUM_REGS];

    logic [1:0]               in_type;
    logic [REG_ADDR_BITS-1:0] in_rd, in_rs1, in_rs2;
    logic [OFFSET_WIDTH-1:0]  in_off;
    logic [OPCODE_WIDTH-1:0]  in_op;

    assign in_type = instr[INSTR_WIDTH-1 -: 2];
    assign in_rd   = instr[INSTR_WIDTH-3 -: REG_ADDR_BITS];
    assign in_rs1  = instr[INSTR_WIDTH-3-REG_ADDR_BITS -: REG_ADDR_BITS];
    assign in_rs2  = instr[INSTR_WIDTH-3-2*REG_ADDR_BITS -: REG_ADDR_BITS];
    assign in_off  = instr[OPCODE_WIDTH +: OFFSET_WIDTH];
    assign in_op   = instr[OPCODE_WIDTH-1:0];

    function automatic logic [DATA_WIDTH-1:0] rd_reg(input logic [REG_ADDR_BITS-1:0] a);
        return (REG0_ZERO && a == '0) ? '0 : regfile[a];
    endfunction

    assign dbg_data = rd_reg(dbg_addr);

    // Outputs are registered from the next-state decision so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cur_type    <= T_NOP;
            cur_rd      <= '0;
            for (int i = 0; i < NUM_REGS; i++) regfile[i] <= DATA_WIDTH'(i);
            operand1    <= '0;
            operand2    <= '0;
            offset      <= '0;
            opcode      <= '1;
            sel1        <= 1'b0;
            sel3        <= 1'b0;
            w_r         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            instr_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: if (instr_valid && instr_ready) begin
                    state       <= DECODE;
                    cur_type    <= in_type;
                    cur_rd      <= in_rd;
                    operand1    <= rd_reg(in_rs1);
                    operand2    <= (in_type == T_ALU) ? rd_reg(in_rs2) : rd_reg(in_rd);
                    offset      <= DATA_WIDTH'(in_off);
                    opcode      <= in_op;
                    sel1        <= in_type == T_ALU;
                    sel3        <= in_type[1];
                    busy        <= 1'b1;
                    done        <= in_type == T_NOP;
                    instr_ready <= 1'b0;
                end
                DECODE: begin
                    state       <= (cur_type == T_NOP) ? IDLE : EXECUTE;
                    busy        <= cur_type != T_NOP;
                    instr_ready <= cur_type == T_NOP;
                    done        <= 1'b0;
                end
                EXECUTE: begin
                    state <= (cur_type == T_ALU) ? WRITE_BACK : MEM_ACCESS;
                    done  <= cur_type != T_LOAD;
                    w_r   <= cur_type == T_STORE;
                end
                MEM_ACCESS: begin
                    state       <= (cur_type == T_STORE) ? IDLE : WRITE_BACK;
                    done        <= cur_type != T_STORE;
                    busy        <= cur_type != T_STORE;
                    instr_ready <= cur_type == T_STORE;
                    w_r         <= 1'b0;
                end
                WRITE_BACK: begin
                    if (!(REG0_ZERO && cur_rd == '0)) regfile[cur_rd] <= result2;
                    state       <= IDLE;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    w_r         <= 1'b0;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cu_multicycle.sv
// tb_cu_multicycle: randomized self-checking bench for cu_multicycle against an instruction-level register model.
module tb_cu_multicycle;
    logic        clk = 1'b0, rst = 1'b1, instr_valid = 1'b0;
    logic        instr_ready, sel1, sel3, w_r, busy, done;
    logic [19:0] instr = '0;
    logic [7:0]  result2 = '0, operand1, operand2, offset, dbg_data;
    logic [3:0]  opcode;
    logic [1:0]  dbg_addr = '0;
    int          n_cmp = 0, n_bad = 0;
    logic [7:0]  model [4];
`ifdef CU_REG0_ZERO_EN
    localparam bit Z = 1'b1;
`else
    localparam bit Z = 1'b0;
`endif

    cu_multicycle dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .result2(result2), .operand1(operand1), .operand2(operand2), .offset(offset), .opcode(opcode),
        .sel1(sel1), .sel3(sel3), .w_r(w_r), .busy(busy), .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) model[i] = 8'(i);
    endtask

    task automatic dump_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            n_cmp++;
            if (dbg_data !== model[i]) begin
                n_bad++;
                $display("FAIL %s reg%0d: got %h want %h", tag, i, dbg_data, model[i]);
            end
        end
    endtask

    // Drives one instruction and checks every cycle until the unit is idle again.
    task automatic run_instr(input logic [1:0] t, input logic [1:0] rd, rs1, rs2,
                             input logic [7:0] off, input logic [3:0] op, input logic [7:0] res);
        int n, w;
        logic [7:0] e1, e2;
        w = 0;
        while (!instr_ready && w < 20) begin @(negedge clk); w++; end
        n_cmp++;
        if (!instr_ready) begin
            n_bad++;
            $display("FAIL ready_timeout: got %b want 1", instr_ready);
            return;
        end
        e1 = Z && rs1 == 0 ? 8'h00 : model[rs1];
        e2 = (t == 2'd1) ? model[rs2] : model[rd];
        if (Z && ((t == 2'd1) ? rs2 : rd) == 0) e2 = 8'h00;
        n = (t == 2'd0) ? 1 : (t == 2'd2) ? 4 : 3;
        instr = {t, rd, rs1, rs2, off, op};
        instr_valid = 1'b1;
        result2 = res;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        instr = 20'($urandom);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({done, w_r, busy, instr_ready} !== {k == n, t == 2'd3 && k == n, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL ctrl t=%0d cyc%0d: got done,w_r,busy,rdy=%b want %b", t, k,
                         {done, w_r, busy, instr_ready}, {k == n, t == 2'd3 && k == n, 1'b1, 1'b0});
            end
            n_cmp++;
            if ({operand1, offset, opcode, sel1, sel3} !== {e1, off, op, t == 2'd1, t[1]}) begin
                n_bad++;
                $display("FAIL datapath t=%0d cyc%0d: got op1=%h off=%h opc=%h s1=%b s3=%b want %h %h %h %b %b",
                         t, k, operand1, offset, opcode, sel1, sel3, e1, off, op, t == 2'd1, t[1]);
            end
            if (t != 2'd0) begin
                n_cmp++;
                if (operand2 !== e2) begin
                    n_bad++;
                    $display("FAIL operand2 t=%0d cyc%0d: got %h want %h", t, k, operand2, e2);
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({done, w_r, busy, instr_ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL idle_after t=%0d: got done,w_r,busy,rdy=%b want 0001", t, {done, w_r, busy, instr_ready});
        end
        if ((t == 2'd1 || t == 2'd2) && !(Z && rd == 0)) model[rd] = res;
        dump_regs("regs_after");
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({instr_ready, opcode, w_r, busy, done, sel1, sel3} !== {1'b1, 4'hF, 5'b0}) begin
            n_bad++;
            $display("FAIL reset_ctrl: got rdy,opc,w_r,busy,done,s1,s3=%b want %b",
                     {instr_ready, opcode, w_r, busy, done, sel1, sel3}, {1'b1, 4'hF, 5'b0});
        end
        n_cmp++;
        if ({operand1, operand2, offset} !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_operands: got %h want 000000", {operand1, operand2, offset});
        end
        if (!Z) dump_regs("reset_regs");
        else begin
            model[0] = 8'h00;
            dump_regs("reset_regs");
        end
    endtask

    task automatic test_alu();
        run_instr(2'd1, 2'd1, 2'd2, 2'd3, 8'h00, 4'h2, 8'h55);
    endtask

    task automatic test_load();
        run_instr(2'd2, 2'd3, 2'd1, 2'd0, 8'h10, 4'h0, 8'hA7);
    endtask

    task automatic test_store();
        run_instr(2'd3, 2'd2, 2'd0, 2'd1, 8'h04, 4'h6, 8'h99);
    endtask

    task automatic test_reg0();
        run_instr(2'd1, 2'd0, 2'd1, 2'd2, 8'h00, 4'h1, 8'hFF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_instr(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                      8'($urandom), 4'($urandom), 8'($urandom));
    endtask

    task automatic test_back_to_back();
        instr = {2'd0, 18'($urandom)};
        instr_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, instr_ready, done} !== {k % 2 == 1, k % 2 == 0, k % 2 == 1}) begin
                n_bad++;
                $display("FAIL back_to_back cyc%0d: got busy,rdy,done=%b want %b", k,
                         {busy, instr_ready, done}, {k % 2 == 1, k % 2 == 0, k % 2 == 1});
            end
        end
        instr_valid = 1'b0;
        dump_regs("b2b_regs");
    endtask

    task automatic test_reset_mid_store();
        instr = {2'd3, 2'd1, 2'd2, 2'd3, 8'h20, 4'h3};
        instr_valid = 1'b1;
        result2 = 8'h3C;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (w_r !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_store_wr: got %b want 1", w_r);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({w_r, busy, done, instr_ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL async_abort: got w_r,busy,done,rdy=%b want 0001", {w_r, busy, done, instr_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        if (Z) model[0] = 8'h00;
        dump_regs("post_abort_regs");
        run_instr(2'd1, 2'd3, 2'd1, 2'd2, 8'h00, 4'h5, 8'h66);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_reg0();
        test_random();
        test_back_to_back();
        test_reset_mid_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
